// File: rtl/divu_pkg.sv
// Shared definitions for the sequential unsigned divider: state encoding, width defaults
// and the divide-by-zero quotient constant.
package divu_pkg;

   localparam int unsigned XLEN_DEFAULT  = 64;
   localparam int unsigned CNT_W_DEFAULT = 7;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = IDLE,
      StBusy = BUSY,
      StDone = DONE
   } state_e;

   localparam logic [XLEN_DEFAULT-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare against the
// divisor and subtract when the trial value is not smaller.
module divu_step #(
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN:0]   rem_i,
   input  logic            q_bit_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN:0]   rem_o,
   output logic            q_bit_o
);

   logic [XLEN:0] trial;
   logic [XLEN:0] diff;
   logic          lt;
   logic          unused_rem_msb;

   // The partial remainder is always below the divisor, so its top bit carries no information.
   assign unused_rem_msb = rem_i[XLEN];

   assign trial   = {rem_i[XLEN-1:0], q_bit_i};
   assign lt      = trial < {1'b0, divisor_i};
   assign diff    = trial - {1'b0, divisor_i};
   assign rem_o   = lt ? trial : diff;
   assign q_bit_o = ~lt;

endmodule

// File: rtl/divu_sequential.sv
// Multi-cycle unsigned divider, one quotient bit per clock, valid/ready on both sides.
// Define DIVU_ZERO_FAST_EN to resolve a zero divisor after one cycle instead of XLEN.
module divu_sequential
   import divu_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o,
   output logic            div_by_zero_o
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  q_q;
   logic [XLEN:0]    rem_q;
   logic [XLEN-1:0]  dvsr_q;
   logic             dbz_q;

   logic [XLEN:0]    step_rem;
   logic             step_bit;

   divu_step #(
      .XLEN (XLEN)
   ) u_step (
      .rem_i     (rem_q),
      .q_bit_i   (q_q[XLEN-1]),
      .divisor_i (dvsr_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_bit)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         q_q     <= '0;
         rem_q   <= '0;
         dvsr_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  dvsr_q  <= divisor_i;
                  q_q     <= dividend_i;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  dbz_q   <= (divisor_i == '0);
                  state_q <= StBusy;
               end
            end
            StBusy: begin
`ifdef DIVU_ZERO_FAST_EN
               // q_q still holds the untouched dividend on the first busy cycle.
               if (dbz_q) begin
                  q_q     <= XLEN'(DIV_ZERO_Q);
                  rem_q   <= {1'b0, q_q};
                  state_q <= StDone;
               end else begin
                  rem_q <= step_rem;
                  q_q   <= {q_q[XLEN-2:0], step_bit};
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(XLEN - 1)) state_q <= StDone;
               end
`else
               rem_q <= step_rem;
               q_q   <= {q_q[XLEN-2:0], step_bit};
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) state_q <= StDone;
`endif
            end
            StDone: begin
               if (out_ready_i) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready_o    = (state_q == StIdle);
   assign out_valid_o   = (state_q == StDone);
   assign quotient_o    = q_q;
   assign remainder_o   = rem_q[XLEN-1:0];
   assign div_by_zero_o = dbz_q & out_valid_o;

endmodule

// File: tb/tb_divu_sequential.sv
// Self-checking bench for divu_sequential: directed vector table, multi-cycle corner
// sequences and randomized operands checked against plain-arithmetic expectations.
module tb_divu_sequential;

   localparam int unsigned XLEN = 64;
`ifdef DIVU_ZERO_FAST_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 64;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] quotient;
   logic [XLEN-1:0] remainder;
   logic            div_by_zero;

   int n_cmp  = 0;
   int n_fail = 0;

   divu_sequential #(
      .XLEN  (XLEN),
      .CNT_W (7)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .dividend_i    (dividend),
      .divisor_i     (divisor),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .quotient_o    (quotient),
      .remainder_o   (remainder),
      .div_by_zero_o (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] q;
      logic [63:0] r;
      logic        dbz;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [63:0] a, input logic [63:0] b);
      int guard = 0;
      while (!in_ready && guard < 300) begin
         tick();
         guard++;
      end
      check("accept_in_ready", {63'd0, in_ready}, 64'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      // Operands need not stay stable after acceptance.
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 300) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("in_ready_after_release", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic run_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] eq, input logic [63:0] er, input logic edbz,
                            input int elat);
      int lat;
      accept(a, b);
      wait_done(lat);
      check({tag, "_latency"}, 64'(lat), 64'(elat));
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
      release_result();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
      check({tag, "_quotient"}, quotient, 64'd0);
      check({tag, "_remainder"}, remainder, 64'd0);
      check({tag, "_dbz"}, {63'd0, div_by_zero}, 64'd0);
   endtask

   vec_t vecs[7];

   initial begin
      logic [63:0] a, b, eq, er, hq, hr;
      logic        hdbz;
      int          lat;

      vecs[0] = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 64};
      vecs[1] = '{64'd5, 64'd10, 64'd0, 64'd5, 1'b0, 64};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64};
      vecs[3] = '{64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, ZLAT};
      vecs[4] = '{64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 64};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64};
      vecs[6] = '{64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 64};

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      tick();
      tick();
      reset = 1'b0;
      check_reset_outputs("reset");

      for (int i = 0; i < 7; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].dbz, vecs[i].lat);
      end

      // Consumer stalls for 10 cycles: result must hold and no new op may be taken.
      accept(64'd100, 64'd7);
      wait_done(lat);
      check("stall_latency", 64'(lat), 64'd64);
      hq   = quotient;
      hr   = remainder;
      hdbz = div_by_zero;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 3);
         tick();
         check("stall_out_valid", {63'd0, out_valid}, 64'd1);
         check("stall_in_ready", {63'd0, in_ready}, 64'd0);
         check("stall_quotient", quotient, 64'd14);
         check("stall_remainder", remainder, 64'd2);
         check("stall_hold", {hq ^ quotient} | {hr ^ remainder}, 64'd0);
         check("stall_dbz", {63'd0, div_by_zero}, {63'd0, hdbz});
      end
      in_valid = 1'b0;
      release_result();

      // Reset mid-operation aborts without producing a result.
      accept(64'h8000_0000_0000_0000, 64'd3);
      for (int i = 0; i < 30; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("midreset");
      run_check("after_reset", 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 64);

      // in_valid pulsed while busy with other operands must be ignored.
      accept(64'd100, 64'd7);
      for (int i = 0; i < 5; i++) tick();
      dividend = 64'd50;
      divisor  = 64'd0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      in_valid = 1'b0;
      wait_done(lat);
      check("busy_ignore_latency", 64'(lat + 8), 64'd64);
      check("busy_ignore_quotient", quotient, 64'd14);
      check("busy_ignore_remainder", remainder, 64'd2);
      check("busy_ignore_dbz", {63'd0, div_by_zero}, 64'd0);
      release_result();

      // Randomized operands against plain arithmetic.
      for (int i = 0; i < 40; i++) begin
         a = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       b = 64'($urandom_range(0, 15));
            1:       b = 64'($urandom);
            2:       b = {$urandom, $urandom} >> $urandom_range(0, 63);
            default: b = {$urandom, $urandom};
         endcase
         if (b == 64'd0) begin
            eq = '1;
            er = a;
         end else begin
            eq = a / b;
            er = a % b;
         end
         run_check($sformatf("rand%0d", i), a, b, eq, er, b == 64'd0,
                   (b == 64'd0) ? ZLAT : 64);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/divu_sequential.md
# divu_sequential

Multi-cycle 64-bit unsigned divider producing quotient and remainder via restoring division, one quotient bit per clock. It is the consumer side of the datapath's unsigned less-than compare: each iteration decides "partial remainder < divisor" and conditionally subtracts. It sits beside the ALU in the execute stage and serves DIVU/REMU through a valid/ready handshake, stalling the core while busy.

## Interface
- XLEN, default 64: operand and result width.
- CNT_W, default 7: iteration counter width; must hold XLEN.
- clk, input, 1: sole clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high; sampled on the rising edge of clk.
- in_valid, input, 1: dividend/divisor valid.
- in_ready, output, 1: divider can accept an operation.
- dividend, input, XLEN: unsigned numerator.
- divisor, input, XLEN: unsigned denominator.
- out_valid, output, 1: quotient/remainder valid.
- out_ready, input, 1: consumer accepts the result.
- quotient, output, XLEN: dividend / divisor, truncated.
- remainder, output, XLEN: dividend mod divisor.
- div_by_zero, output, 1: the completed operation had divisor == 0; qualified by out_valid.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, latch divisor; load the quotient shift register with dividend; clear the partial remainder (XLEN+1 bits) and the counter; go to BUSY.
- BUSY, once per cycle: trial = {rem[XLEN-1:0], q[XLEN-1]}. If trial < {1'b0, divisor}, rem <= trial and shift 0 into q; otherwise rem <= trial - divisor and shift 1 into q. Increment the counter. After the iteration where counter == XLEN-1, go to DONE.
- DONE: out_valid = 1; quotient = q, remainder = rem[XLEN-1:0]. Hold all outputs stable until out_ready is high, then go to IDLE.
- Divide by zero: the algorithm naturally yields quotient = all ones and remainder = dividend, per RISC-V. div_by_zero = 1 in DONE.
- The subtraction is 65-bit; the carry-out is unused because trial >= divisor is guaranteed when subtracting.
- in_valid is ignored outside IDLE. Operands are not required to stay stable after acceptance.
- Reset in any state: state returns to IDLE and the current operation is aborted with no result.

## Timing
- Reset values: in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, state = IDLE, counter = 0.
- Accept at edge N, giving BUSY from N. out_valid rises after edge N+XLEN, a latency of 64 cycles.
- Results are held indefinitely while out_ready = 0.
- DONE with out_ready = 1 at edge M gives IDLE after M, so in_ready = 1 in cycle M+1. There is no same-cycle accept in DONE, so the initiation interval is at least 66 cycles.
- in_ready is a pure function of state, with no combinational path from in_valid.

## Configuration
- DIVU_ZERO_FAST_EN:
  - Defined: divisor == 0 at accept goes directly to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1. Latency is 1 cycle.
  - Undefined: a zero divisor runs the full XLEN iterations; results and flag are identical and latency is 64 cycles.

## Structure
- Shared package divu_pkg holds:
  - state encoding localparams: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  - XLEN and CNT_W defaults;
  - the all-ones divide-by-zero quotient constant.
- One sub-module, divu_step: combinational single iteration. Inputs are rem, the incoming q bit, and divisor; outputs are next rem and the quotient bit. It contains the 65-bit less-than compare and subtract.
- The top level holds the FSM, counter, registers and handshake.

## Test plan
- 100 / 7 → quotient 14, remainder 2, div_by_zero 0; out_valid exactly 64 cycles after accept.
- 5 / 10 → quotient 0, remainder 5. 0xFFFFFFFFFFFFFFFF / 1 → quotient all ones, remainder 0.
- 0x1234 / 0 → quotient 0xFFFFFFFFFFFFFFFF, remainder 0x1234, div_by_zero 1; latency 1 with DIVU_ZERO_FAST_EN, 64 without.
- out_ready held low 10 cycles in DONE → outputs stable and in_ready 0 throughout; in_ready = 1 the cycle after out_ready rises.
- reset asserted 30 cycles into 0x8000000000000000 / 3 → next cycle IDLE, all outputs at reset values; a following 9 / 3 returns quotient 3, remainder 0.
- in_valid pulsed during BUSY with different operands → ignored; the original result is unchanged.
